id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the 64-bit ripple-carry execute ALU.
- Captures decoded operands, immediate, register indices and control bits each cycle.
- Generates the ALU's 4-bit Operation code and carry-in from ALUOp/funct fields.
- Resolves operand forwarding from EX/MEM and MEM/WB, so the ALU sees the final A/B directly.

Parameters:
- N, 64, datapath width of operands, immediate and forwarded results.
- REG_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  decode-stage slot holds a real instruction
- stall  input  1  hold all EX registers this cycle
- flush  input  1  replace captured instruction with a bubble
- id_rs1_data  input  N  register-file read port 1
- id_rs2_data  input  N  register-file read port 2
- id_imm  input  N  sign-extended immediate
- id_rs1, id_rs2, id_rd  input  REG_W each  register indices
- id_alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- id_funct3  input  3  instruction funct3
- id_funct7b5  input  1  instruction bit 30
- id_alu_src  input  1  1 selects immediate for B
- id_reg_write, id_mem_read, id_mem_write, id_branch  input  1 each  control bits
- exm_reg_write  input  1  EX/MEM writes a register
- exm_rd  input  REG_W  EX/MEM destination
- exm_result  input  N  EX/MEM ALU result
- mwb_reg_write  input  1  MEM/WB writes a register
- mwb_rd  input  REG_W  MEM/WB destination
- mwb_result  input  N  MEM/WB writeback value
- ex_valid  output  1  EX slot holds a real instruction
- ex_alu_a  output  N  final ALU operand A
- ex_alu_b  output  N  final ALU operand B (immediate or forwarded rs2)
- ex_store_data  output  N  forwarded rs2, for stores
- ex_operation  output  4  ALU Operation code
- ex_alu_carry_in  output  1  ALU carry-in
- ex_rd  output  REG_W  destination index
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  output  1 each  registered control bits
- ex_illegal  output  1  unsupported funct combination captured

Behaviour:
- All state updates on posedge clk. Priority: reset > flush > stall > load.
- Reset: every register cleared; ex_valid=0, ex_operation=4'b0000, ex_alu_carry_in=0, all control bits 0, ex_illegal=0, ex_rd=0.
- Flush: bubble; ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch and ex_illegal=0; the data registers may hold any value. Flush and stall together: flush wins.
- Stall (no flush): every register holds. The forwarding muxes stay live.
- Load: registers take the id_* values. If id_valid=0, the control bits load as 0 (bubble).
- Latency: 1 cycle from the id_* inputs to the registered fields. Forwarding is combinational from exm_*/mwb_* (0 cycles).
- Operation decode (registered):
  - alu_op 00 -> 0010 ADD.
  - alu_op 01 -> 0110 SUB.
  - alu_op 10, funct3 000: 0010 ADD when b5=0, 0110 SUB when b5=1.
  - alu_op 10: funct3 111 -> 0000 AND; 110 -> 0001 OR; 010 -> 0111 SLT.
  - alu_op 11: same as 10, except funct3 000 is always ADD.
  - Any other funct -> 0010 with ex_illegal=1.
- ex_alu_carry_in=1 when ex_operation is 0110 or 0111, else 0.
- Forward A: if exm_reg_write and exm_rd!=0 and exm_rd==rs1, use exm_result. Else if mwb_reg_write and mwb_rd!=0 and mwb_rd==rs1, use mwb_result. Else use the registered rs1_data. EX/MEM has priority over MEM/WB.
- rs2 is forwarded identically into ex_store_data.
- ex_alu_b = registered imm if alu_src=1, else the forwarded rs2.
- Register x0 is never forwarded.

Optional Feature:
- Macro ID_EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined: ex_alu_a and ex_store_data come straight from the registered rs1/rs2 data, and the exm_*/mwb_* inputs are ignored. The hazard unit must then stall the pipeline instead.

Test Plan:
- Reset asserted 2 cycles with id_valid=1 -> ex_valid=0, ex_operation=0000, ex_alu_carry_in=0, ex_reg_write=0.
- R-type SUB (alu_op=10, funct3=000, b5=1), rs1_data=10, rs2_data=3, then clock -> ex_operation=0110, carry_in=1, ex_alu_a=10, ex_alu_b=3.
- I-type SLTI with imm=-1 (64'hFFFF_FFFF_FFFF_FFFF), alu_src=1 -> ex_operation=0111, carry_in=1, ex_alu_b=all ones.
- rs1=5, exm_rd=5 with exm_result=0x44, mwb_rd=5 with mwb_result=0x99, both writing -> ex_alu_a=0x44. With exm_rd=0 instead -> ex_alu_a=0x99. With rs1=0 and rd=0 -> ex_alu_a = the registered data.
- Load ADD, then stall 3 cycles while id_* changes -> outputs unchanged. Stall and flush in the same cycle -> ex_valid=0 and ex_reg_write=0 next cycle.
- alu_op=10, funct3=001 -> ex_operation=0010 and ex_illegal=1. A subsequent flush -> ex_illegal=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU control decode and operand forwarding
//
// Purpose:
//   Captures decoded operands, immediate, register indices and control bits from
//   the decode stage each cycle. Produces the registered 4-bit ALU Operation code
//   and carry-in, and presents final ALU operands A/B with forwarding resolved.
//
// Optional feature (macro ID_EX_FORWARD_EN):
//   Defined   - operands A and rs2 are forwarded from EX/MEM (priority) or MEM/WB.
//   Undefined - operands come straight from the registered register-file data and
//               the exm_*/mwb_* inputs are ignored (hazards are handled by stalling).
//
// Ports:
//   clk, reset                 - rising-edge clock, synchronous active-high reset
//   id_valid, stall, flush     - slot valid, hold all EX registers, insert bubble
//   id_rs1_data, id_rs2_data   - register-file read data
//   id_imm                     - sign-extended immediate
//   id_rs1, id_rs2, id_rd      - register indices
//   id_alu_op, id_funct3,
//   id_funct7b5, id_alu_src    - ALU decode fields and B-operand select
//   id_reg_write, id_mem_read,
//   id_mem_write, id_branch    - control bits
//   exm_*, mwb_*               - forwarding sources from EX/MEM and MEM/WB
//   ex_valid                   - EX slot holds a real instruction
//   ex_alu_a, ex_alu_b         - final ALU operands
//   ex_store_data              - forwarded rs2 for stores
//   ex_operation               - ALU Operation code
//   ex_alu_carry_in            - ALU carry-in (set for SUB/SLT)
//   ex_rd                      - destination index
//   ex_reg_write, ex_mem_read,
//   ex_mem_write, ex_branch    - registered control bits
//   ex_illegal                 - unsupported funct combination captured

module id_ex_stage #(
    parameter int N     = 64,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [N-1:0]     id_rs1_data,
    input  logic [N-1:0]     id_rs2_data,
    input  logic [N-1:0]     id_imm,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic [1:0]       id_alu_op,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic             exm_reg_write,
    input  logic [REG_W-1:0] exm_rd,
    input  logic [N-1:0]     exm_result,
    input  logic             mwb_reg_write,
    input  logic [REG_W-1:0] mwb_rd,
    input  logic [N-1:0]     mwb_result,
    output logic             ex_valid,
    output logic [N-1:0]     ex_alu_a,
    output logic [N-1:0]     ex_alu_b,
    output logic [N-1:0]     ex_store_data,
    output logic [3:0]       ex_operation,
    output logic             ex_alu_carry_in,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic             ex_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic [N-1:0]     rs1_data_q;
    logic [N-1:0]     rs2_data_q;
    logic [N-1:0]     imm_q;
    logic [REG_W-1:0] rs1_q;
    logic [REG_W-1:0] rs2_q;
    logic             alu_src_q;

    logic [3:0]       op_d;
    logic             illegal_d;

    // ALU control decode from ALUOp/funct fields
    always_comb begin
        op_d      = OP_ADD;
        illegal_d = 1'b0;
        case (id_alu_op)
            2'b00: op_d = OP_ADD;
            2'b01: op_d = OP_SUB;
            default: begin
                case (id_funct3)
                    // funct7 bit 5 selects SUB only for R-type; I-type ADDI has no SUBI
                    3'b000: op_d = (id_alu_op == 2'b10 && id_funct7b5) ? OP_SUB : OP_ADD;
                    3'b111: op_d = OP_AND;
                    3'b110: op_d = OP_OR;
                    3'b010: op_d = OP_SLT;
                    default: begin
                        op_d      = OP_ADD;
                        illegal_d = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
            ex_operation <= 4'b0000;
            ex_rd        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            alu_src_q    <= 1'b0;
        end else if (flush) begin
            // Bubble: only control state is cleared, data registers are don't-care
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!stall) begin
            // A non-valid slot loads as a bubble so it can never write state
            ex_valid     <= id_valid;
            ex_reg_write <= id_reg_write & id_valid;
            ex_mem_read  <= id_mem_read  & id_valid;
            ex_mem_write <= id_mem_write & id_valid;
            ex_branch    <= id_branch    & id_valid;
            ex_illegal   <= illegal_d    & id_valid;
            ex_operation <= op_d;
            ex_rd        <= id_rd;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            alu_src_q    <= id_alu_src;
        end
    end

    // SUB and SLT both compute A + ~B + 1 in the ripple-carry adder
    assign ex_alu_carry_in = (ex_operation == OP_SUB) || (ex_operation == OP_SLT);

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded
    always_comb begin
        ex_alu_a = rs1_data_q;
        if (exm_reg_write && exm_rd != '0 && exm_rd == rs1_q) begin
            ex_alu_a = exm_result;
        end else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == rs1_q) begin
            ex_alu_a = mwb_result;
        end
    end

    always_comb begin
        ex_store_data = rs2_data_q;
        if (exm_reg_write && exm_rd != '0 && exm_rd == rs2_q) begin
            ex_store_data = exm_result;
        end else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == rs2_q) begin
            ex_store_data = mwb_result;
        end
    end
`else
    assign ex_alu_a      = rs1_data_q;
    assign ex_store_data = rs2_data_q;

    // Forwarding sources and captured indices are deliberately left unconnected
    logic unused_fwd;
    assign unused_fwd = ^{exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result, rs1_q, rs2_q};
`endif

    assign ex_alu_b = alu_src_q ? imm_q : ex_store_data;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, stall, flush;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7b5, id_alu_src;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [63:0] exm_result, mwb_result;
    logic        ex_valid, ex_alu_carry_in, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_illegal;
    logic [63:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [3:0]  ex_operation;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;

    // Reference state: what the EX slot should hold after each edge
    logic        m_valid, m_rw, m_mr, m_mw, m_br, m_ill, m_src;
    logic [3:0]  m_op;
    logic [63:0] m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
        .ex_store_data(ex_store_data), .ex_operation(ex_operation),
        .ex_alu_carry_in(ex_alu_carry_in), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal)
    );

    // Returns {illegal, operation} from the ALUOp/funct table
    function automatic logic [4:0] ref_decode(input logic [1:0] aop, input logic [2:0] f3,
                                              input logic b5);
        if (aop == 2'b00) return 5'b0_0010;
        if (aop == 2'b01) return 5'b0_0110;
        case (f3)
            3'b000:  return (aop == 2'b10 && b5) ? 5'b0_0110 : 5'b0_0010;
            3'b111:  return 5'b0_0000;
            3'b110:  return 5'b0_0001;
            3'b010:  return 5'b0_0111;
            default: return 5'b1_0010;
        endcase
    endfunction

    function automatic logic [63:0] ref_fwd(input logic [4:0] idx, input logic [63:0] d);
`ifdef ID_EX_FORWARD_EN
        if (exm_reg_write && exm_rd != 5'd0 && exm_rd == idx) return exm_result;
        if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == idx) return mwb_result;
`endif
        return d;
    endfunction

    task automatic model_clock();
        logic [4:0] dec;
        dec = ref_decode(id_alu_op, id_funct3, id_funct7b5);
        if (reset) begin
            {m_valid, m_rw, m_mr, m_mw, m_br, m_ill, m_src} = '0;
            m_op = 4'd0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        end else if (flush) begin
            {m_valid, m_rw, m_mr, m_mw, m_br, m_ill} = '0;
        end else if (!stall) begin
            m_valid = id_valid;
            m_rw = id_reg_write && id_valid;
            m_mr = id_mem_read && id_valid;
            m_mw = id_mem_write && id_valid;
            m_br = id_branch && id_valid;
            m_ill = dec[4] && id_valid;
            m_op = dec[3:0];
            m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_src = id_alu_src;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] aop, input logic [2:0] f3, input logic b5,
                             input logic src, input logic [63:0] d1, input logic [63:0] d2,
                             input logic [63:0] imm);
        id_valid = 1'b1; id_alu_op = aop; id_funct3 = f3; id_funct7b5 = b5;
        id_alu_src = src; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0; id_branch = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
        mwb_reg_write = 1'b0; mwb_rd = '0; mwb_result = '0;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
        set_instr(2'b10, 3'b000, 1'b1, 1'b0, 64'd7, 64'd8, 64'd9);
        tick();
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
        checks++; if (ex_operation !== 4'b0000) begin failures++; $display("FAIL reset_op got=%b exp=0000", ex_operation); end
        checks++; if (ex_alu_carry_in !== 1'b0) begin failures++; $display("FAIL reset_cin got=%b exp=0", ex_alu_carry_in); end
        checks++; if (ex_reg_write !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", ex_reg_write); end
        checks++; if (ex_illegal !== 1'b0 || ex_rd !== 5'd0) begin failures++; $display("FAIL reset_ill_rd got=%b/%0d exp=0/0", ex_illegal, ex_rd); end
        reset = 1'b0;
    endtask

    task automatic test_sub();
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
        set_instr(2'b10, 3'b000, 1'b1, 1'b0, 64'd10, 64'd3, 64'd0);
        tick();
        checks++; if (ex_operation !== 4'b0110) begin failures++; $display("FAIL sub_op got=%b exp=0110", ex_operation); end
        checks++; if (ex_alu_carry_in !== 1'b1) begin failures++; $display("FAIL sub_cin got=%b exp=1", ex_alu_carry_in); end
        checks++; if (ex_alu_a !== 64'd10) begin failures++; $display("FAIL sub_a got=%0d exp=10", ex_alu_a); end
        checks++; if (ex_alu_b !== 64'd3) begin failures++; $display("FAIL sub_b got=%0d exp=3", ex_alu_b); end
        checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin failures++; $display("FAIL sub_ctrl got=%b%b exp=11", ex_valid, ex_reg_write); end
    endtask

    task automatic test_slti();
        set_instr(2'b11, 3'b010, 1'b1, 1'b1, 64'd5, 64'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        checks++; if (ex_operation !== 4'b0111) begin failures++; $display("FAIL slti_op got=%b exp=0111", ex_operation); end
        checks++; if (ex_alu_carry_in !== 1'b1) begin failures++; $display("FAIL slti_cin got=%b exp=1", ex_alu_carry_in); end
        checks++; if (ex_alu_b !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL slti_b got=%h exp=all ones", ex_alu_b); end
        checks++; if (ex_store_data !== 64'd6) begin failures++; $display("FAIL slti_store got=%0d exp=6", ex_store_data); end
    endtask

    task automatic test_forward();
        logic [63:0] exp_a;
        id_rs1 = 5'd5; id_rs2 = 5'd6; id_rd = 5'd7;
        set_instr(2'b10, 3'b000, 1'b0, 1'b0, 64'h11, 64'h12, 64'h0);
        tick();
        exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 64'h44;
        mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 64'h99;
        #1;
`ifdef ID_EX_FORWARD_EN
        exp_a = 64'h44;
`else
        exp_a = 64'h11;
`endif
        checks++; if (ex_alu_a !== exp_a) begin failures++; $display("FAIL fwd_exm got=%h exp=%h", ex_alu_a, exp_a); end
        exm_rd = 5'd0;
        #1;
`ifdef ID_EX_FORWARD_EN
        exp_a = 64'h99;
`else
        exp_a = 64'h11;
`endif
        checks++; if (ex_alu_a !== exp_a) begin failures++; $display("FAIL fwd_mwb got=%h exp=%h", ex_alu_a, exp_a); end
        id_rs1 = 5'd0;
        id_rs1_data = 64'h22;
        tick();
        mwb_rd = 5'd0;
        #1;
        checks++; if (ex_alu_a !== 64'h22) begin failures++; $display("FAIL fwd_x0 got=%h exp=22", ex_alu_a); end
        exm_reg_write = 1'b0; mwb_reg_write = 1'b0;
    endtask

    task automatic test_stall_flush();
        id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd7;
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 64'h1234, 64'h55, 64'h8);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(2'b10, 3'($urandom_range(0, 7)), 1'b1, 1'b1, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom});
            id_rd = 5'($urandom_range(8, 31)); id_valid = 1'($urandom_range(0, 1));
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin failures++; $display("FAIL stall_ctrl[%0d] got=%b%b exp=11", i, ex_valid, ex_reg_write); end
            checks++; if (ex_operation !== 4'b0010 || ex_rd !== 5'd7) begin failures++; $display("FAIL stall_op_rd[%0d] got=%b/%0d exp=0010/7", i, ex_operation, ex_rd); end
            checks++; if (ex_alu_a !== 64'h1234 || ex_alu_b !== 64'h55) begin failures++; $display("FAIL stall_ab[%0d] got=%h/%h exp=1234/55", i, ex_alu_a, ex_alu_b); end
        end
        flush = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin failures++; $display("FAIL stall_flush got=%b%b exp=00", ex_valid, ex_reg_write); end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_illegal();
        set_instr(2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'd2, 64'd3);
        tick();
        checks++; if (ex_operation !== 4'b0010) begin failures++; $display("FAIL ill_op got=%b exp=0010", ex_operation); end
        checks++; if (ex_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b exp=1", ex_illegal); end
        flush = 1'b1;
        tick();
        checks++; if (ex_illegal !== 1'b0) begin failures++; $display("FAIL ill_flush got=%b exp=0", ex_illegal); end
        flush = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] exp_a, exp_s, exp_b;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1_data = {$urandom, $urandom}; id_rs2_data = {$urandom, $urandom};
            id_imm = {$urandom, $urandom};
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 31));
            id_alu_op = 2'($urandom_range(0, 3)); id_funct3 = 3'($urandom_range(0, 7));
            id_funct7b5 = 1'($urandom_range(0, 1)); id_alu_src = 1'($urandom_range(0, 1));
            id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = 1'($urandom_range(0, 1));
            id_mem_write = 1'($urandom_range(0, 1)); id_branch = 1'($urandom_range(0, 1));
            tick();
            exm_reg_write = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3));
            exm_result = {$urandom, $urandom};
            mwb_reg_write = 1'($urandom_range(0, 1)); mwb_rd = 5'($urandom_range(0, 3));
            mwb_result = {$urandom, $urandom};
            #1;
            exp_a = ref_fwd(m_rs1, m_rs1d);
            exp_s = ref_fwd(m_rs2, m_rs2d);
            exp_b = m_src ? m_imm : exp_s;
            checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch} !== {m_valid, m_rw, m_mr, m_mw, m_br}) begin
                failures++; $display("FAIL rnd_ctrl[%0d] got=%b exp=%b", i, {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, {m_valid, m_rw, m_mr, m_mw, m_br}); end
            if (m_valid) begin
                checks++; if (ex_operation !== m_op || ex_illegal !== m_ill) begin failures++; $display("FAIL rnd_op[%0d] got=%b/%b exp=%b/%b", i, ex_operation, ex_illegal, m_op, m_ill); end
                checks++; if (ex_alu_carry_in !== (m_op == 4'b0110 || m_op == 4'b0111)) begin failures++; $display("FAIL rnd_cin[%0d] got=%b op=%b", i, ex_alu_carry_in, m_op); end
                checks++; if (ex_alu_a !== exp_a) begin failures++; $display("FAIL rnd_a[%0d] got=%h exp=%h", i, ex_alu_a, exp_a); end
                checks++; if (ex_alu_b !== exp_b || ex_store_data !== exp_s) begin failures++; $display("FAIL rnd_b[%0d] got=%h/%h exp=%h/%h", i, ex_alu_b, ex_store_data, exp_b, exp_s); end
                checks++; if (ex_rd !== m_rd) begin failures++; $display("FAIL rnd_rd[%0d] got=%0d exp=%0d", i, ex_rd, m_rd); end
            end
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sub();
        test_slti();
        test_forward();
        test_stall_flush();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
